decoder_n_scan: RTL

Parametrised N:2^N one-hot decoder with a registered output and a built-in scan sequencer. It is the next generation of the team's fixed-width enable decoders. In direct mode it decodes a loaded select value. In scan mode it steps the active output through all 2^N positions, up or down, holding each for a programmable dwell time. Typical uses are row/column strobing, round-robin channel selection and one-hot test pattern generation.

---
 rtl/decoder_n_scan.sv | 100 ++++++++++
 1 files changed

// File: rtl/decoder_n_scan.sv
// decoder_n_scan: N:2^N one-hot decoder with a registered output and a
// built-in scan sequencer. In direct mode the output follows a loaded index.
// In scan mode the index walks up or down, and each position is held for
// DWELL enabled cycles.
module decoder_n_scan #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              mode_in,
  input  logic              dir_in,
  input  logic              load_in,
  input  logic [N-1:0]      sel_in,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx_out,
  output logic              wrap_out
);

  localparam int W  = 2**N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  IDX_ONE  = N'(1);
  localparam logic [N-1:0]  IDX_TOP  = {N{1'b1}};

  logic [N-1:0]  idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wrap_nxt;
  logic [W-1:0]  hot;

  // Next-state selection: load beats a scan advance. Direct mode parks the
  // dwell counter at 0. A disabled scan holds both cnt and idx.
  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (load_in) begin
      idx_nxt = sel_in;
      cnt_nxt = '0;
    end else if (!mode_in) begin
      cnt_nxt = '0;
    end else if (en_in) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        idx_nxt  = dir_in ? (idx - IDX_ONE) : (idx + IDX_ONE);
        wrap_nxt = dir_in ? (idx == '0) : (idx == IDX_TOP);
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  // One compare lane per output bit. Each lane decodes the index that is
  // written at this edge, so out and idx_out change together.
  for (genvar g = 0; g < W; g++) begin : g_lane
    decoder_n_scan_lane #(.N(N), .IDX(g)) u_lane (
      .idx (idx_nxt),
      .en  (en_in),
      .hit (hot[g])
    );
  end

  // State and output registers. Reset is synchronous and has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      out      <= '0;
      wrap_out <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      out      <= hot;
      wrap_out <= wrap_nxt;
    end
  end

  assign idx_out = idx;

endmodule

// decoder_n_scan_lane: one output bit of the decoder. It is high when the
// block is enabled and the index equals this lane's position.
module decoder_n_scan_lane #(
  parameter int N   = 4,
  parameter int IDX = 0
) (
  input  logic [N-1:0] idx,
  input  logic         en,
  output logic         hit
);

  localparam logic [N-1:0] POS = N'(IDX);

  assign hit = en && (idx == POS);

endmodule
